ir_pulse_tx: RTL and testbench
==============================

Name: ir_pulse_tx

Overview:
- Parametrised pulse-distance IR transmitter. It is the generalised successor to the team's fixed 32-bit Samsung encoder.
- Accepts one command word per frame over a valid/ready handshake. Emits leader, DATA_W bit cells and stop mark, then enforces an inter-frame gap.
- Provides a bare envelope and a carrier-modulated output for the IR LED driver. Sits between the remote-control command logic and the LED pin.

Parameters:
- DATA_W, 32: command bits per frame (1..64).
- MSB_FIRST, 1: 1 transmits bit DATA_W-1 first; 0 transmits bit 0 first.
- CNT_W, 20: phase/tick counter width; every duration parameter must be < 2^CNT_W.
- LEAD_MARK, 225000: leader mark length, clk cycles (must be >= 1).
- LEAD_SPACE, 225000: leader space length, clk cycles (must be >= 1).
- BIT_MARK, 28000: mark length at start of every bit cell.
- ZERO_SPACE, 28000: space after mark for a 0 bit.
- ONE_SPACE, 84500: space after mark for a 1 bit.
- STOP_MARK, 28000: trailing mark length.
- GAP, 100000: minimum low time after stop mark before next accept; 0 allowed, meaning no gap.
- CARRIER_HALF, 658: carrier half-period in clk cycles (38 kHz at 50 MHz); 0 disables the carrier, so ir_mod equals ir_env.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  DATA_W  command word to transmit.
- cmd_valid  in  1  cmd_data is valid.
- cmd_ready  out  1  block can accept a command.
- abort  in  1  synchronous abort of the frame in progress.
- busy  out  1  frame or gap in progress.
- done  out  1  one-cycle pulse on normal frame completion.
- ir_env  out  1  unmodulated envelope; 1 = mark.
- ir_mod  out  1  ir_env ANDed with carrier.

Behaviour:
- Reset:
  - Asynchronous, takes effect mid-frame with no completion.
  - On reset: state IDLE, cmd_ready=1, busy=0, done=0, ir_env=0, ir_mod=0, counters and shift register 0.
- States: IDLE, LMARK, LSPACE, BMARK, BSPACE, SMARK, GAP.
- IDLE: cmd_ready=1. Accept on the rising edge where cmd_valid & cmd_ready & !abort.
  - Latch cmd_data, bit index 0, phase counter 0.
  - Go to LMARK.
  - cmd_ready falls and busy rises in the same cycle ir_env rises (first cycle after accept).
- Phase timing: every phase lasts exactly its parameter in cycles. The counter counts 0..N-1 and the state advances when counter==N-1. There is no extra cycle between phases; the original encoder's +1 per phase is removed.
- LMARK: ir_env=1 for LEAD_MARK cycles -> LSPACE.
- LSPACE: ir_env=0 for LEAD_SPACE cycles -> BMARK.
- BMARK: ir_env=1 for BIT_MARK cycles -> BSPACE.
  - The current bit is sampled from the latched word: MSB_FIRST ? word[DATA_W-1-idx] : word[idx].
- BSPACE: ir_env=0 for ONE_SPACE if the bit is 1, else ZERO_SPACE.
  - At the end: if idx==DATA_W-1 -> SMARK; else idx++ -> BMARK.
- SMARK: ir_env=1 for STOP_MARK cycles.
  - At the end, done=1 for the next single cycle.
  - Then -> GAP if GAP>0, else -> IDLE. Zero-gap case: done pulses in the same cycle cmd_ready returns.
- GAP: ir_env=0 for GAP cycles, busy=1, cmd_ready=0 -> IDLE.
- Frame length: LEAD_MARK + LEAD_SPACE + DATA_W*BIT_MARK + n1*ONE_SPACE + n0*ZERO_SPACE + STOP_MARK cycles, where n1/n0 are the counts of 1/0 bits.
- Abort:
  - Sampled every cycle. In any non-IDLE state it forces IDLE on the next edge: ir_env=ir_mod=0, no done, no gap.
  - In IDLE, abort blocks acceptance; cmd_ready stays 1 but the handshake does not complete.
- Input isolation: cmd_data/cmd_valid changes while busy are ignored. The latched word is used, and no command is queued.
- Carrier:
  - A dedicated counter reloads to 0 and carrier phase to 1 at every mark-phase entry, so each mark starts on a high carrier half.
  - The carrier toggles every CARRIER_HALF cycles.
  - ir_mod = ir_env & carrier, registered together with ir_env so both share latency.
  - During spaces and IDLE, ir_mod=0.
- Outputs: all outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Common setup: DATA_W=4, MSB_FIRST=1, LEAD_MARK=8, LEAD_SPACE=4, BIT_MARK=2, ZERO_SPACE=2, ONE_SPACE=6, STOP_MARK=2, GAP=5, CARRIER_HALF=0.
- Send 4'b1010 -> ir_env runs 8 high, 4 low, then 2H/6L, 2H/2L, 2H/6L, 2H/2L, 2H (38 cycles). done one cycle after stop. cmd_ready returns exactly 5 cycles after done. ir_mod==ir_env throughout.
- Same setup with MSB_FIRST=0 and 4'b0001 -> first bit space is 6 cycles, remaining three are 2 cycles. Frame length 34 cycles.
- cmd_valid held high with 4'hF then 4'h0 back-to-back -> second frame's ir_env rises exactly GAP+1 cycles after the first done. cmd_data changes mid-frame do not alter the first frame.
- Assert abort during the 2nd bit space -> ir_env/ir_mod 0 and cmd_ready 1 on the next edge. No done. Next command is accepted immediately.
- Assert async reset mid-leader (between clock edges) -> all outputs 0 and cmd_ready 1 before the next clk edge. A following frame is correct.
- CARRIER_HALF=3, send 4'b0000 -> within every mark, ir_mod runs 3H/3L from mark start, truncated at mark end. ir_mod is never high while ir_env=0.

Source files
------------

// File: rtl/ir_pulse_tx.sv
// ir_pulse_tx: parametrised pulse-distance IR transmitter.
//
// Takes one command word per frame over a valid/ready handshake. It sends a
// leader mark and space, DATA_W bit cells (a fixed mark followed by a short
// or long space) and a stop mark, and then holds the line low for GAP cycles
// before it accepts the next word. Every phase lasts exactly its parameter
// in clk cycles.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cmd_data   command word to transmit (latched on accept)
//   cmd_valid  cmd_data is valid
//   cmd_ready  block can accept a command (high only in IDLE)
//   abort      synchronous abort of the frame in progress
//   busy       frame or gap in progress
//   done       one-cycle pulse on normal frame completion
//   ir_env     unmodulated envelope, 1 = mark
//   ir_mod     ir_env ANDed with the carrier
//
// All outputs are registered from the next-state logic, so they change on the
// same edge as the state they describe.

module ir_pulse_tx #(
    parameter int DATA_W       = 32,
    parameter int MSB_FIRST    = 1,
    parameter int CNT_W        = 20,
    parameter int LEAD_MARK    = 225000,
    parameter int LEAD_SPACE   = 225000,
    parameter int BIT_MARK     = 28000,
    parameter int ZERO_SPACE   = 28000,
    parameter int ONE_SPACE    = 84500,
    parameter int STOP_MARK    = 28000,
    parameter int GAP          = 100000,
    parameter int CARRIER_HALF = 658
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ir_env,
    output logic              ir_mod
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] LM_LAST  = CNT_W'(LEAD_MARK - 1);
    localparam logic [CNT_W-1:0] LS_LAST  = CNT_W'(LEAD_SPACE - 1);
    localparam logic [CNT_W-1:0] BM_LAST  = CNT_W'(BIT_MARK - 1);
    localparam logic [CNT_W-1:0] ZS_LAST  = CNT_W'(ZERO_SPACE - 1);
    localparam logic [CNT_W-1:0] OS_LAST  = CNT_W'(ONE_SPACE - 1);
    localparam logic [CNT_W-1:0] SM_LAST  = CNT_W'(STOP_MARK - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CAR_LAST = CNT_W'((CARRIER_HALF > 0) ? CARRIER_HALF - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LMARK,
        ST_LSPACE,
        ST_BMARK,
        ST_BSPACE,
        ST_SMARK,
        ST_GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  phase_cnt;
    logic [CNT_W-1:0]  phase_last;
    logic              phase_end;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  bit_idx_next;
    logic              last_bit;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_rev;
    logic [DATA_W-1:0] word_sel;
    logic              cur_bit;
    logic              accept;
    logic              done_next;
    logic              mark_cur;
    logic              mark_next;
    logic              mark_entry;
    logic [CNT_W-1:0]  car_cnt;
    logic [CNT_W-1:0]  car_cnt_next;
    logic              car_ph;
    logic              car_ph_next;

    // Bit order is handled by reversing the latched word, so the bit index
    // always counts up from 0 regardless of MSB_FIRST.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            word_rev[i] = word[DATA_W-1-i];
        end
        word_sel = (MSB_FIRST != 0) ? word_rev : word;
        cur_bit  = word_sel[bit_idx];
        last_bit = (bit_idx == IDX_LAST);
    end

    // Length of the phase currently running; the bit space depends on the bit.
    always_comb begin
        phase_last = '0;
        case (state)
            ST_LMARK:  phase_last = LM_LAST;
            ST_LSPACE: phase_last = LS_LAST;
            ST_BMARK:  phase_last = BM_LAST;
            ST_BSPACE: phase_last = cur_bit ? OS_LAST : ZS_LAST;
            ST_SMARK:  phase_last = SM_LAST;
            ST_GAP:    phase_last = GAP_LAST;
            default:   phase_last = '0;
        endcase
        phase_end = (phase_cnt == phase_last);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort outranks phase completion, so an abort on the
    // last stop-mark cycle suppresses done and skips the gap.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        done_next    = 1'b0;
        bit_idx_next = bit_idx;
        if (state == ST_IDLE) begin
            if (cmd_valid && cmd_ready && !abort) begin
                accept       = 1'b1;
                bit_idx_next = '0;
                state_next   = ST_LMARK;
            end
        end else if (abort) begin
            state_next = ST_IDLE;
        end else if (phase_end) begin
            case (state)
                ST_LMARK:  state_next = ST_LSPACE;
                ST_LSPACE: state_next = ST_BMARK;
                ST_BMARK:  state_next = ST_BSPACE;
                ST_BSPACE: begin
                    if (last_bit) begin
                        state_next = ST_SMARK;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        state_next   = ST_BMARK;
                    end
                end
                ST_SMARK: begin
                    done_next  = 1'b1;
                    state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP:    state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Carrier: restarts on a high half at every mark entry so each mark
    // begins with the LED on; with CARRIER_HALF=0 it is held high.
    always_comb begin
        mark_cur   = (state == ST_LMARK) || (state == ST_BMARK) || (state == ST_SMARK);
        mark_next  = (state_next == ST_LMARK) || (state_next == ST_BMARK) ||
                     (state_next == ST_SMARK);
        mark_entry = mark_next && !mark_cur;
        car_cnt_next = car_cnt;
        car_ph_next  = car_ph;
        if (CARRIER_HALF == 0) begin
            car_cnt_next = '0;
            car_ph_next  = 1'b1;
        end else if (mark_entry) begin
            car_cnt_next = '0;
            car_ph_next  = 1'b1;
        end else if (car_cnt == CAR_LAST) begin
            car_cnt_next = '0;
            car_ph_next  = !car_ph;
        end else begin
            car_cnt_next = car_cnt + 1'b1;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            bit_idx   <= '0;
            word      <= '0;
            car_cnt   <= '0;
            car_ph    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ir_env    <= 1'b0;
            ir_mod    <= 1'b0;
        end else begin
            if (state_next != state || state_next == ST_IDLE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            if (accept) begin
                word <= cmd_data;
            end
            bit_idx   <= bit_idx_next;
            car_cnt   <= car_cnt_next;
            car_ph    <= car_ph_next;
            cmd_ready <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            done      <= done_next;
            ir_env    <= mark_next;
            ir_mod    <= mark_next && car_ph_next;
        end
    end

endmodule

// File: tb/tb_ir_pulse_tx.sv
// tb_ir_pulse_tx: scoreboard bench for ir_pulse_tx.
//
// Two instances share clock and reset: dut A transmits MSB first with the
// carrier disabled, dut B transmits LSB first with a 3-cycle carrier half.
// Each stimulus pushes the cycle-by-cycle expected outputs of its frame into
// that instance's queue; a per-instance monitor pops one entry per falling
// clock edge and compares.

module tb_ir_pulse_tx;

    localparam int GAP_C = 5;

    typedef struct packed {
        logic env;
        logic mod;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = 5'b00010;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_a, data_b;
    logic       valid_a, valid_b, abort_a, abort_b;
    logic       ready_a, busy_a, done_a, env_a, mod_a;
    logic       ready_b, busy_b, done_b, env_b, mod_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a_e, mon_b_e;
    int   idx_a = 0;
    int   idx_b = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ir_pulse_tx #(
        .DATA_W(4), .MSB_FIRST(1), .CNT_W(8), .LEAD_MARK(8), .LEAD_SPACE(4),
        .BIT_MARK(2), .ZERO_SPACE(2), .ONE_SPACE(6), .STOP_MARK(2),
        .GAP(GAP_C), .CARRIER_HALF(0)
    ) dut_a (
        .clk(clk), .reset(reset), .cmd_data(data_a), .cmd_valid(valid_a),
        .cmd_ready(ready_a), .abort(abort_a), .busy(busy_a), .done(done_a),
        .ir_env(env_a), .ir_mod(mod_a)
    );

    ir_pulse_tx #(
        .DATA_W(4), .MSB_FIRST(0), .CNT_W(8), .LEAD_MARK(8), .LEAD_SPACE(4),
        .BIT_MARK(2), .ZERO_SPACE(2), .ONE_SPACE(6), .STOP_MARK(2),
        .GAP(GAP_C), .CARRIER_HALF(3)
    ) dut_b (
        .clk(clk), .reset(reset), .cmd_data(data_b), .cmd_valid(valid_b),
        .cmd_ready(ready_b), .abort(abort_b), .busy(busy_b), .done(done_b),
        .ir_env(env_b), .ir_mod(mod_b)
    );

    // One comparison of all five outputs against the expected vector.
    task automatic checkOutput(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: env/mod/busy/ready/done got %b%b%b%b%b expected %b%b%b%b%b",
                     name, got.env, got.mod, got.busy, got.ready, got.done,
                     want.env, want.mod, want.busy, want.ready, want.done);
        end
    endtask

    // Monitors: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            mon_a_e = q_a.pop_front();
            checkOutput($sformatf("dutA item %0d", idx_a),
                        {env_a, mod_a, busy_a, ready_a, done_a}, mon_a_e);
            idx_a++;
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0) begin
            mon_b_e = q_b.pop_front();
            checkOutput($sformatf("dutB item %0d", idx_b),
                        {env_b, mod_b, busy_b, ready_b, done_b}, mon_b_e);
            idx_b++;
        end
    end

    task automatic push_item(input int which, input exp_t e);
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    // Expected trace: the presenting cycle (idle, ready), then the frame as
    // runs of mark/space, then the gap with done in its first cycle. A limit
    // >= 0 truncates the frame after that many cycles and omits the gap.
    task automatic push_frame(input int which, input logic [3:0] data, input int limit);
        int   len[$];
        bit   lvl[$];
        bit   msb;
        bit   b;
        int   half;
        int   n;
        exp_t e;
        msb  = (which == 0);
        half = (which == 0) ? 0 : 3;
        push_item(which, IDLE_E);
        len.push_back(8); lvl.push_back(1'b1);
        len.push_back(4); lvl.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            b = msb ? data[3-i] : data[i];
            len.push_back(2);         lvl.push_back(1'b1);
            len.push_back(b ? 6 : 2); lvl.push_back(1'b0);
        end
        len.push_back(2); lvl.push_back(1'b1);
        n = 0;
        for (int r = 0; r < len.size(); r++) begin
            for (int p = 0; p < len[r]; p++) begin
                if (limit >= 0 && n >= limit) return;
                e.env   = lvl[r];
                e.mod   = lvl[r] && (half == 0 || ((p / half) % 2 == 0));
                e.busy  = 1'b1;
                e.ready = 1'b0;
                e.done  = 1'b0;
                push_item(which, e);
                n++;
            end
        end
        if (limit >= 0) return;
        for (int g = 0; g < GAP_C; g++) begin
            e.env   = 1'b0;
            e.mod   = 1'b0;
            e.busy  = 1'b1;
            e.ready = 1'b0;
            e.done  = (g == 0);
            push_item(which, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits until both scoreboards are empty, then lands just after a rising edge.
    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((q_a.size() != 0 || q_b.size() != 0) && n < 600);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL drain timeout: %0d/%0d entries left, required 0",
                     q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
        #1;
    endtask

    // One complete frame on the chosen instance, starting from idle.
    task automatic applyStimulus(input int which, input logic [3:0] data);
        push_frame(which, data, -1);
        if (which == 0) begin valid_a = 1'b1; data_a = data; end
        else            begin valid_b = 1'b1; data_b = data; end
        tick();
        if (which == 0) valid_a = 1'b0;
        else            valid_b = 1'b0;
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0;
        data_a  = 4'h0; data_b  = 4'h0;
        for (int i = 0; i < 3; i++) begin
            push_item(0, IDLE_E);
            push_item(1, IDLE_E);
        end
        #22;
        reset = 1'b0;
        wait_drain();

        $display("[TB] MSB-first frame 4'b1010");
        applyStimulus(0, 4'b1010);

        $display("[TB] LSB-first frame 4'b0001 with carrier");
        applyStimulus(1, 4'b0001);

        $display("[TB] carrier shape on frame 4'b0000");
        applyStimulus(1, 4'b0000);

        $display("[TB] back-to-back 4'hF then 4'h0 with cmd_valid held");
        push_frame(0, 4'hF, -1);
        push_frame(0, 4'h0, -1);
        valid_a = 1'b1;
        data_a  = 4'hF;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 10) data_a = 4'h0;
            if (i == 55) begin
                data_a  = 4'hA;
                valid_a = 1'b0;
            end
        end
        wait_drain();

        $display("[TB] abort in idle blocks acceptance");
        push_item(0, IDLE_E);
        push_item(0, IDLE_E);
        valid_a = 1'b1;
        abort_a = 1'b1;
        data_a  = 4'hF;
        tick();
        valid_a = 1'b0;
        abort_a = 1'b0;
        wait_drain();

        $display("[TB] abort during second bit space");
        push_frame(0, 4'b1010, 23);
        valid_a = 1'b1;
        data_a  = 4'b1010;
        tick();
        valid_a = 1'b0;
        repeat (22) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        applyStimulus(0, 4'b0110);

        $display("[TB] asynchronous reset mid-leader");
        push_frame(0, 4'b1010, 3);
        push_item(0, IDLE_E);
        valid_a = 1'b1;
        data_a  = 4'b1010;
        tick();
        valid_a = 1'b0;
        repeat (3) tick();
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset mid-leader before edge",
                    {env_a, mod_a, busy_a, ready_a, done_a}, IDLE_E);
        #4;
        reset = 1'b0;
        wait_drain();
        applyStimulus(0, 4'b1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
